// File: rtl/load_use_hazard_unit_pkg.sv
// Shared pipeline constants for the load-use hazard unit.
// Holds register-file geometry, producer latencies, the register-number
// type and a helper that clamps a latency-derived count into a counter width.
package load_use_hazard_unit_pkg;

  // Architectural register file geometry.
  localparam int NUM_REGS = 8;
  localparam int REG_W    = 3;

  // Per-register readiness counter width.
  localparam int CNT_W    = 2;

  // Cycles from EX entry until a producer's result is forwardable to EX.
  localparam int LOAD_LAT = 2;
  localparam int ALU_LAT  = 1;

  // Register number as carried through the ID stage.
  typedef logic [REG_W-1:0] reg_num_t;

  // Stall cycles a dependent instruction needs behind a producer of the
  // given latency, clamped into a counter of the given width. A latency of
  // 1 (or less) means the result is forwardable right away, so no stall.
  function automatic int stall_cycles(input int lat, input int width);
    int raw;
    int max_val;
    raw     = lat - 1;
    max_val = (1 << width) - 1;
    if (raw < 0) begin
      return 0;
    end else if (raw > max_val) begin
      return max_val;
    end else begin
      return raw;
    end
  endfunction

endpackage : load_use_hazard_unit_pkg

// File: rtl/load_use_hazard_unit_ready_counter.sv
// Readiness counter for one architectural register.
// Value 0 means the register is forwardable now; N means N more stall cycles.
// Priority at the clock edge: reset, clear (flush), set (new producer
// accepted), then a non-wrapping decrement toward zero.
module hazard_ready_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             set,
  input  logic [CNT_W-1:0] set_value,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Next count: flush wins, then a new producer, otherwise count down to 0.
  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (set) begin
      cnt_next = set_value;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule : hazard_ready_counter

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard unit: issue-side companion of the EX forwarding unit.
// Tracks, per architectural register, how many more cycles must pass before
// an in-flight result can be forwarded, and stalls the ID instruction only
// when one of the sources it actually reads is not yet forwardable.
// Optional build macro: HAZARD_STALL_STATS_EN adds a saturating 16-bit
// stall-cycle counter on stall_count_out.
module load_use_hazard_unit
  import load_use_hazard_unit_pkg::*;
#(
  parameter int NUM_REGS = load_use_hazard_unit_pkg::NUM_REGS,
  parameter int REG_W    = load_use_hazard_unit_pkg::REG_W,
  parameter int CNT_W    = load_use_hazard_unit_pkg::CNT_W,
  parameter int LOAD_LAT = load_use_hazard_unit_pkg::LOAD_LAT
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             issue_valid_in,
  input  logic [REG_W-1:0] Rsrc_ID_in,
  input  logic [REG_W-1:0] Rdst_ID_in,
  input  logic             Rsrc_use_ID_in,
  input  logic             Rdst_use_ID_in,
  input  logic [REG_W-1:0] Rdst1_ID_in,
  input  logic [REG_W-1:0] Rdst2_ID_in,
  input  logic             Rdst1_wb_ID_in,
  input  logic             Rdst2_wb_ID_in,
  input  logic             mem_read_ID_in,
  output logic             stall_out,
  output logic             hold_pc_out,
  output logic             hold_ifid_out,
  output logic             bubble_idex_out
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [15:0]      stall_count_out
`endif
);

  // Count loaded for a load destination; an ALU result is ready at once.
  localparam int               LOAD_SET_INT = stall_cycles(LOAD_LAT, CNT_W);
  localparam int               ALU_SET_INT  = stall_cycles(ALU_LAT, CNT_W);
  localparam logic [CNT_W-1:0] LOAD_SET     = CNT_W'(LOAD_SET_INT);
  localparam logic [CNT_W-1:0] ALU_SET      = CNT_W'(ALU_SET_INT);

  logic [CNT_W-1:0]    ready_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] reg_busy;
  logic [NUM_REGS-1:0] src_hit;
  logic [NUM_REGS-1:0] dst_hit;
  logic [NUM_REGS-1:0] set_vec;
  logic [CNT_W-1:0]    set_value;
  logic                src_busy;
  logic                dst_busy;
  logic                hazard;
  logic                accept;

  // Value written into every destination counter of an accepted instruction.
  assign set_value = mem_read_ID_in ? LOAD_SET : ALU_SET;

  // One readiness counter per register, plus per-register query and
  // destination-match decode. Matching Rdst1/Rdst2 simply OR into one set.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign reg_busy[gi] = (ready_cnt[gi] != '0);
      assign src_hit[gi]  = reg_busy[gi] && (Rsrc_ID_in == REG_W'(gi));
      assign dst_hit[gi]  = reg_busy[gi] && (Rdst_ID_in == REG_W'(gi));
      assign set_vec[gi]  = accept &&
                            ((Rdst1_wb_ID_in && (Rdst1_ID_in == REG_W'(gi))) ||
                             (Rdst2_wb_ID_in && (Rdst2_ID_in == REG_W'(gi))));

      hazard_ready_counter #(
        .CNT_W (CNT_W)
      ) u_ready_counter (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .clear     (flush_in),
        .set       (set_vec[gi]),
        .set_value (set_value),
        .cnt       (ready_cnt[gi])
      );
    end
  endgenerate

  // Hazard query: stall only for sources the ID instruction really reads;
  // a flush in the same cycle overrides the stall since ID is being killed.
  always_comb begin
    src_busy  = |src_hit;
    dst_busy  = |dst_hit;
    hazard    = issue_valid_in &&
                ((Rsrc_use_ID_in && src_busy) || (Rdst_use_ID_in && dst_busy));
    stall_out = hazard && !flush_in;
    accept    = issue_valid_in && !stall_out && !flush_in;
  end

  assign hold_pc_out     = stall_out;
  assign hold_ifid_out   = stall_out;
  assign bubble_idex_out = stall_out | flush_in;

`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] stall_count_reg;

  // Saturating count of stalled cycles; only reset clears it, not flush.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      stall_count_reg <= '0;
    end else if (stall_out && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'd1;
    end
  end

  assign stall_count_out = stall_count_reg;
`endif

endmodule : load_use_hazard_unit

// File: tb/tb_load_use_hazard_unit.sv
// Directed testbench for load_use_hazard_unit (default LOAD_LAT=2, so a
// load followed by a dependent reader costs exactly one stall cycle).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_load_use_hazard_unit;

  logic       clk_in;
  logic       rst_n_in;
  logic       flush_in;
  logic       issue_valid_in;
  logic [2:0] Rsrc_ID_in;
  logic [2:0] Rdst_ID_in;
  logic       Rsrc_use_ID_in;
  logic       Rdst_use_ID_in;
  logic [2:0] Rdst1_ID_in;
  logic [2:0] Rdst2_ID_in;
  logic       Rdst1_wb_ID_in;
  logic       Rdst2_wb_ID_in;
  logic       mem_read_ID_in;
  logic       stall_out;
  logic       hold_pc_out;
  logic       hold_ifid_out;
  logic       bubble_idex_out;
`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] stall_count_out;
`endif

  int total = 0;
  int bad   = 0;

  load_use_hazard_unit dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .flush_in        (flush_in),
    .issue_valid_in  (issue_valid_in),
    .Rsrc_ID_in      (Rsrc_ID_in),
    .Rdst_ID_in      (Rdst_ID_in),
    .Rsrc_use_ID_in  (Rsrc_use_ID_in),
    .Rdst_use_ID_in  (Rdst_use_ID_in),
    .Rdst1_ID_in     (Rdst1_ID_in),
    .Rdst2_ID_in     (Rdst2_ID_in),
    .Rdst1_wb_ID_in  (Rdst1_wb_ID_in),
    .Rdst2_wb_ID_in  (Rdst2_wb_ID_in),
    .mem_read_ID_in  (mem_read_ID_in),
    .stall_out       (stall_out),
    .hold_pc_out     (hold_pc_out),
    .hold_ifid_out   (hold_ifid_out),
    .bubble_idex_out (bubble_idex_out)
`ifdef HAZARD_STALL_STATS_EN
    ,
    .stall_count_out (stall_count_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Present one ID-stage instruction.
  task automatic drive(input logic v,
                       input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rd, input logic rdu,
                       input logic [2:0] d1, input logic d1w,
                       input logic [2:0] d2, input logic d2w,
                       input logic mr);
    issue_valid_in = v;
    Rsrc_ID_in     = rs;
    Rsrc_use_ID_in = rsu;
    Rdst_ID_in     = rd;
    Rdst_use_ID_in = rdu;
    Rdst1_ID_in    = d1;
    Rdst1_wb_ID_in = d1w;
    Rdst2_ID_in    = d2;
    Rdst2_wb_ID_in = d2w;
    mem_read_ID_in = mr;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // Advance past the next rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    flush_in = 1'b1;
    drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    total++;
    if (hold_pc_out !== 1'b0) begin bad++; $display("FAIL reset_hold_pc: got %b want 0", hold_pc_out); end
    total++;
    if (hold_ifid_out !== 1'b0) begin bad++; $display("FAIL reset_hold_ifid: got %b want 0", hold_ifid_out); end
    total++;
    if (bubble_idex_out !== 1'b1) begin bad++; $display("FAIL reset_bubble_flush: got %b want 1", bubble_idex_out); end
    flush_in = 1'b0;
    #1;
    total++;
    if (bubble_idex_out !== 1'b0) begin bad++; $display("FAIL reset_bubble_noflush: got %b want 0", bubble_idex_out); end
`ifdef HAZARD_STALL_STATS_EN
    total++;
    if (stall_count_out !== 16'd0) begin bad++; $display("FAIL reset_stall_count: got %0d want 0", stall_count_out); end
`endif
    $display("test_reset: outputs checked while in reset");
    idle();
    tick();
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    // load R3
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL load_issue_stall: got %b want 0", stall_out); end
    tick();
    // reader of R3 (Rsrc), writes R4 via ALU
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL load_use_stall: got %b want 1", stall_out); end
    total++;
    if (bubble_idex_out !== 1'b1) begin bad++; $display("FAIL load_use_bubble: got %b want 1", bubble_idex_out); end
    total++;
    if (hold_pc_out !== 1'b1 || hold_ifid_out !== 1'b1) begin
      bad++; $display("FAIL load_use_holds: got pc=%b ifid=%b want 1/1", hold_pc_out, hold_ifid_out);
    end
    tick();
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL load_use_release: got %b want 0", stall_out); end
    total++;
    if (bubble_idex_out !== 1'b0) begin bad++; $display("FAIL load_use_release_bubble: got %b want 0", bubble_idex_out); end
    $display("test_load_use: load R3 then reader R3, one stall cycle");
    tick();
    idle();
    tick();
  endtask

  task automatic test_alu_use();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL alu_issue_stall: got %b want 0", stall_out); end
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL alu_use_stall: got %b want 0", stall_out); end
    total++;
    if (bubble_idex_out !== 1'b0) begin bad++; $display("FAIL alu_use_bubble: got %b want 0", bubble_idex_out); end
    $display("test_alu_use: ALU R2 then Rdst reader R2, no stall");
    tick();
    idle();
    tick();
  endtask

  task automatic test_independent();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL indep_middle_stall: got %b want 0", stall_out); end
    tick();
    drive(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL indep_reader_stall: got %b want 0", stall_out); end
    $display("test_independent: load R5, independent, reader R5, no stall");
    tick();
    idle();
    tick();
  endtask

  task automatic test_invalid();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1);
    tick();
    // dependent reader present but not valid: no stall
    drive(1'b0, 3'd2, 1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL invalid_reader_stall: got %b want 0", stall_out); end
    // valid but reads neither operand: no stall
    drive(1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    #1;
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL unused_operand_stall: got %b want 0", stall_out); end
    $display("test_invalid: invalid or non-reading instruction behind load R2");
    tick();
    idle();
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 1'b1);
    tick();
    // dependent reader, itself a load of R0, killed by flush
    flush_in = 1'b1;
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall_out); end
    total++;
    if (bubble_idex_out !== 1'b1) begin bad++; $display("FAIL flush_bubble: got %b want 1", bubble_idex_out); end
    total++;
    if (hold_pc_out !== 1'b0) begin bad++; $display("FAIL flush_hold_pc: got %b want 0", hold_pc_out); end
    tick();
    flush_in = 1'b0;
    // R6 cleared, and the flushed load of R0 was never registered
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_after_stall: got %b want 0", stall_out); end
    $display("test_flush: load R6, flush with dependent reader in ID");
    tick();
    idle();
    tick();
  endtask

  task automatic test_dual_dest();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 3'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd7, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL dual_stall: got %b want 1", stall_out); end
    // Rdst=R1 alone must also stall
    Rsrc_use_ID_in = 1'b0;
    #1;
    total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL dual_rdst1_only: got %b want 1", stall_out); end
    Rsrc_use_ID_in = 1'b1;
    tick();
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL dual_release: got %b want 0", stall_out); end
    $display("test_dual_dest: load R1+R7, reader of both, one stall cycle");
    tick();
    // Rdst1 write disabled: only R7 becomes busy
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 3'd7, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL wb_disabled_stall: got %b want 0", stall_out); end
    Rsrc_ID_in = 3'd7;
    #1;
    total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL wb2_enabled_stall: got %b want 1", stall_out); end
    $display("test_dual_dest: Rdst1 wb off, Rdst2 wb on");
    idle();
    tick();
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b1) begin bad++; $display("FAIL midreset_pre_stall: got %b want 1", stall_out); end
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL midreset_post_stall: got %b want 0", stall_out); end
    tick();
    // reset wins over an accepted load in the same cycle
    rst_n_in = 1'b0;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
    tick();
    rst_n_in = 1'b1;
    drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk_in);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL reset_over_load: got %b want 0", stall_out); end
    $display("test_mid_reset: reset with pending R3 count");
    tick();
    idle();
    tick();
  endtask

`ifdef HAZARD_STALL_STATS_EN
  task automatic test_stats();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1);
      tick();
      drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      tick();
      tick();
    end
    idle();
    @(negedge clk_in);
    total++;
    if (stall_count_out !== 16'd3) begin bad++; $display("FAIL stats_count: got %0d want 3", stall_count_out); end
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    @(negedge clk_in);
    total++;
    if (stall_count_out !== 16'd0) begin bad++; $display("FAIL stats_reset: got %0d want 0", stall_count_out); end
    $display("test_stats: three stall events then reset");
    tick();
  endtask
`endif

  initial begin
    rst_n_in = 1'b0;
    flush_in = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_alu_use();
    test_independent();
    test_invalid();
    test_flush();
    test_dual_dest();
    test_mid_reset();
`ifdef HAZARD_STALL_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_load_use_hazard_unit

// File: doc/load_use_hazard_unit.md
Name: load_use_hazard_unit

Overview:
- Issue-side counterpart to the EX-stage forwarding unit: tracks when each in-flight destination register (Rdst1/Rdst2) will first become forwardable.
- Stalls the decode stage only when forwarding cannot yet supply a source the ID-stage instruction needs, e.g. load-use.
- Sits between ID and ID/EX; drives PC hold, IF/ID hold and ID/EX bubble insertion.

Parameters:
- NUM_REGS, 8, architectural register count.
- REG_W, 3, register number width.
- CNT_W, 2, per-register readiness counter width.
- LOAD_LAT, 2, cycles from EX entry until a load result is forwardable to EX; ALU latency fixed at 1.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  reset, synchronous, active-low.
- flush_in  input  1  pipeline flush (branch/interrupt); kills in-flight producers.
- issue_valid_in  input  1  valid instruction in ID.
- Rsrc_ID_in  input  REG_W  source register number in ID.
- Rdst_ID_in  input  REG_W  Rdst (read-as-operand) number in ID.
- Rsrc_use_ID_in  input  1  ID instruction reads Rsrc.
- Rdst_use_ID_in  input  1  ID instruction reads Rdst.
- Rdst1_ID_in  input  REG_W  first destination written by ID instruction.
- Rdst2_ID_in  input  REG_W  second destination written by ID instruction.
- Rdst1_wb_ID_in  input  1  Rdst1 write enable.
- Rdst2_wb_ID_in  input  1  Rdst2 write enable.
- mem_read_ID_in  input  1  ID instruction is a load (its destinations use LOAD_LAT).
- stall_out  output  1  hazard present; combinational from registered counters and ID inputs.
- hold_pc_out  output  1  equals stall_out.
- hold_ifid_out  output  1  equals stall_out.
- bubble_idex_out  output  1  insert NOP into ID/EX; equals stall_out | flush_in.

Behaviour:
- State: ready_cnt[NUM_REGS] of CNT_W bits. 0 means forwardable now; N means N more stall cycles required.
- Reset (rst_n_in=0 at edge): all ready_cnt=0. Outputs then: stall_out=0, hold_pc_out=0, hold_ifid_out=0, bubble_idex_out=flush_in.
- Reset mid-operation discards all pending counts; no stall survives reset.
- Hazard condition: issue_valid_in & ((Rsrc_use_ID_in & ready_cnt[Rsrc_ID_in]!=0) | (Rdst_use_ID_in & ready_cnt[Rdst_ID_in]!=0)).
- stall_out = hazard condition & ~flush_in.
- Accept = issue_valid_in & ~stall_out & ~flush_in.
- Per-edge update, in priority order:
  - flush_in: all counters cleared.
  - Otherwise, every nonzero counter decrements by 1. Never wraps below 0.
  - Then, on accept, for each enabled destination: ready_cnt[dst] = mem_read_ID_in ? LOAD_LAT-1 : 0. This assignment overrides the decrement for that register.
- Rdst1==Rdst2 with both enabled: single write with the same value; no conflict.
- A stalled instruction is not registered; it re-presents next cycle and re-evaluates.
- Flush and hazard in the same cycle: no stall; bubble asserted; counters cleared.
- LOAD_LAT-1 must fit CNT_W; values above 2**CNT_W-1 saturate at max.
- Latency: a load followed immediately by a dependent instruction gives exactly LOAD_LAT-1 stall cycles. An ALU producer gives 0.

Optional Feature:
- Macro HAZARD_STALL_STATS_EN.
- Defined:
  - Adds output stall_count_out (16 bit). Increments on each edge where stall_out=1; saturates at 0xFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared pipeline package holds: REG_W, NUM_REGS, LOAD_LAT, ALU latency constant, register-number typedef.
- One sub-module, hazard_ready_counter: a single register's CNT_W-bit counter with set/decrement/clear ports, instantiated NUM_REGS times.
- Top level holds the query compare and stall logic.

Test Plan:
- Load R3 accepted, next ID reads Rsrc=R3 -> stall_out=1 for exactly 1 cycle; bubble_idex_out=1 that cycle; instruction then accepted with stall_out=0.
- ALU writes R2, next ID reads Rdst=R2 -> stall_out=0 throughout; no bubble.
- Load R5, then an independent instruction (R1,R4), then a reader of R5 -> no stall at any point; counter already 0 when the reader arrives.
- Load R6 issued, flush_in=1 next cycle while a dependent reader is in ID -> stall_out=0, bubble_idex_out=1, ready_cnt[6]=0 afterwards.
- Load with Rdst1=R1, Rdst2=R7 (both wb); next reader uses Rsrc=R7 and Rdst=R1 -> one stall cycle, then accept.
- rst_n_in=0 asserted while ready_cnt[3]=1 with an R3 reader in ID -> stall_out=0 the cycle after reset. With HAZARD_STALL_STATS_EN: count 3 stall events -> stall_count_out=3; reset -> 0.
